// File: rtl/sound_frame_seq.sv
// rtl/sound_frame_seq.sv - 8-step frame sequencer and sample capture scheduler for the sound unit
module sound_frame_seq #(
    parameter int unsigned FS_DIV     = 8192,
    parameter logic [31:0] SAMPLE_INC = 32'd49152000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sound_enable,
    output logic        clk_length_ctr,
    output logic        clk_sweep,
    output logic        clk_vol_env,
    output logic        clk_freq_div,
    output logic [2:0]  step,
    output logic        length_idle,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [15:0] left_out,
    output logic [15:0] right_out,
    output logic [7:0]  overrun_cnt
);

    localparam logic [15:0] PRESC_LAST = 16'(FS_DIV - 1);

    logic [15:0] r_presc;
    logic [2:0]  r_step;
    logic        r_length_ctr;
    logic        r_sweep;
    logic        r_vol_env;
    logic        r_freq_div;

    logic [31:0] r_acc;
    logic        r_valid;
    logic [15:0] r_left;
    logic [15:0] r_right;
    logic [7:0]  r_overrun;

    logic        w_tick;
    logic [32:0] w_acc_sum;
    logic        w_capture;

    assign w_tick    = (r_presc == PRESC_LAST);
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, SAMPLE_INC};
    assign w_capture = w_acc_sum[32];

    // Disabling the unit drops any pulse that would follow a tick in this cycle.
    always_ff @(posedge clk) begin
        if (rst || !sound_enable) begin
            r_presc      <= 16'd0;
            r_step       <= 3'd0;
            r_length_ctr <= 1'b0;
            r_sweep      <= 1'b0;
            r_vol_env    <= 1'b0;
            r_freq_div   <= 1'b0;
        end else begin
            r_freq_div <= ~r_freq_div;
            if (w_tick) begin
                r_presc      <= 16'd0;
                r_step       <= r_step + 3'd1;
                r_length_ctr <= ~r_step[0];
                r_sweep      <= (r_step == 3'd2) || (r_step == 3'd6);
                r_vol_env    <= (r_step == 3'd7);
            end else begin
                r_presc      <= r_presc + 16'd1;
                r_length_ctr <= 1'b0;
                r_sweep      <= 1'b0;
                r_vol_env    <= 1'b0;
            end
        end
    end

    // A capture always wins over a transfer; it only counts as an overrun when
    // the held sample was neither accepted nor already consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= 32'd0;
            r_valid   <= 1'b0;
            r_left    <= 16'd0;
            r_right   <= 16'd0;
            r_overrun <= 8'd0;
        end else begin
            r_acc <= w_acc_sum[31:0];
            if (w_capture) begin
                r_left  <= left_in;
                r_right <= right_in;
                r_valid <= 1'b1;
                if (r_valid && !sample_ready && (r_overrun != 8'hFF)) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign clk_length_ctr = r_length_ctr;
    assign clk_sweep      = r_sweep;
    assign clk_vol_env    = r_vol_env;
    assign clk_freq_div   = r_freq_div;
    assign step           = r_step;
    assign length_idle    = r_step[0];
    assign sample_valid   = r_valid;
    assign left_out       = r_left;
    assign right_out      = r_right;
    assign overrun_cnt    = r_overrun;

endmodule
